ahb_lite_eic_bridge: RTL
========================

// Module: ahb_lite_eic_bridge
// PURPOSE
//  AHB-Lite slave front end that feeds the mfp_eic_core register port.
//  Converts AHB address/data-phase transfers into the core's read_addr/read_data
//  and write_addr/write_data/write_enable interface.
//  Rejects unsupported transfers with a two-cycle ERROR response.
//  Sits between the system AHB-Lite bus and mfp_eic_core.
// PARAMETERS
//  ADDR_WIDTH  5  core register index width (= `EIC_ADDR_WIDTH); index = HADDR[ADDR_WIDTH+1:2]
// PORTS
//  HCLK          in   1           bus clock; also clocks the core
//  HRESETn       in   1           asynchronous active-low reset
//  HADDR         in   32          AHB address
//  HBURST        in   3           ignored (every beat is handled as SINGLE)
//  HSEL          in   1           slave select
//  HSIZE         in   3           transfer size; only 3'b010 (word) is legal
//  HTRANS        in   2           IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//  HWDATA        in   32          write data, valid in data phase
//  HWRITE        in   1           1=write, 0=read
//  HRDATA        out  32          read data, valid in data phase
//  HREADY        out  1           transfer done / slave ready
//  HRESP         out  1           0=OKAY, 1=ERROR
//  read_addr     out  ADDR_WIDTH  core read index
//  read_data     in   32          core read data; combinational from read_addr
//  write_addr    out  ADDR_WIDTH  core write index
//  write_data    out  32          core write data
//  write_enable  out  1           core write strobe; core registers on the HCLK edge
// BEHAVIOUR
//  - Active transfer (ACT) = HSEL & HTRANS[1] & HREADY.
//    IDLE/BUSY or HSEL=0 -> OKAY, zero wait, no core access.
//  - Illegal transfer = ACT & (HSIZE!=3'b010 | HADDR[1:0]!=0).
//  - FSM: S_IDLE, S_READ, S_WRITE, S_ERR1, S_ERR2. Decisions are taken on the HCLK edge ending the address phase.
//    - IDLE/READ/WRITE --ACT legal read--> S_READ
//    - IDLE/READ/WRITE --ACT legal write--> S_WRITE
//    - IDLE/READ/WRITE --illegal--> S_ERR1
//    - IDLE/READ/WRITE --no ACT--> S_IDLE
//    - S_ERR1 -> S_ERR2 unconditionally.
//    - S_ERR2 samples ACT as in S_IDLE.
//  - Address capture: addr_q <= HADDR[ADDR_WIDTH+1:2] on every ACT, legal or not.
//    read_addr = addr_q; write_addr = addr_q.
//  - Read data phase (S_READ): HRDATA = read_data, HREADY=1, HRESP=0. Zero wait states.
//  - Write data phase (S_WRITE): write_enable=1, write_data=HWDATA, HREADY=1, HRESP=0.
//    The core commits at the end of that cycle.
//  - Outside S_READ, HRDATA=32'h0. write_enable is 1 only in S_WRITE.
//  - Error: S_ERR1 drives HREADY=0, HRESP=1. S_ERR2 drives HREADY=1, HRESP=1. No core write in either.
//  - Back-to-back: a write then a read of the same index returns the new value with no stall.
//    The write commits at the end of the write data phase, before the read data phase.
//  - Pipelining: the next address phase overlaps the current data phase.
//    Because HREADY is low in S_ERR1, no new transfer is accepted there.
//  - Width rule: HADDR bits above ADDR_WIDTH+1 are ignored (the block aliases across its decoded window).
//  - Reset (async, any state, mid-transfer included): state=S_IDLE, addr_q=0.
//    HREADY=1, HRESP=0, HRDATA=0, write_enable=0 immediately. Any in-flight write is dropped.
// TESTING
//  1. Reset -> HREADY=1, HRESP=0, write_enable=0, HRDATA=0. Assert reset while in S_WRITE -> write_enable drops without waiting for a clock.
//  2. Word write HADDR=0x08, HWDATA=0x0F -> one cycle with write_enable=1, write_addr=2, write_data=0x0F. Read of 0x08 next -> HRDATA=0x0F, HREADY=1.
//  3. Back-to-back write 0x0C=0x03 then read 0x0C with no idle -> read data phase returns 0x03, zero waits.
//  4. HSIZE=3'b000 write to 0x04 -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1, write_enable never asserted. Same for HADDR=0x06 with HSIZE=3'b010.
//  5. HTRANS=IDLE or BUSY with HSEL=1, and NONSEQ with HSEL=0 -> no core access, OKAY, HREADY=1.
//  6. Burst: SEQ reads 0x00,0x04,0x08 back-to-back -> three consecutive zero-wait data phases with read_addr=0,1,2.

Source files
------------

// File: rtl/ahb_lite_eic_bridge.sv
// ahb_lite_eic_bridge
//   AHB-Lite slave front end for the mfp_eic_core register port. It turns
//   pipelined AHB address/data-phase transfers into the core's simple
//   read/write register interface. Word-sized, word-aligned transfers are
//   handled with zero wait states. Any other active transfer gets a
//   two-cycle ERROR response and never reaches the core.
//
// Parameters
//   ADDR_WIDTH    core register index width; index = HADDR[ADDR_WIDTH+1:2]
//
// Ports
//   HCLK          bus clock, also clocks the core
//   HRESETn       asynchronous active-low reset
//   HADDR         AHB address (upper bits alias across the decoded window)
//   HBURST        ignored, every beat is treated as SINGLE
//   HSEL          slave select
//   HSIZE         transfer size, only word (3'b010) is legal
//   HTRANS        IDLE/BUSY/NONSEQ/SEQ
//   HWDATA        write data, valid in the data phase
//   HWRITE        1 = write, 0 = read
//   HRDATA        read data, driven only in a read data phase
//   HREADY        slave ready, low only in the first error cycle
//   HRESP         0 = OKAY, 1 = ERROR
//   read_addr     core read index
//   read_data     core read data, combinational from read_addr
//   write_addr    core write index
//   write_data    core write data
//   write_enable  core write strobe, the core commits on the HCLK edge
module ahb_lite_eic_bridge #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           HADDR,
  input  logic [2:0]            HBURST,
  input  logic                  HSEL,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic [31:0]           HWDATA,
  input  logic                  HWRITE,
  output logic [31:0]           HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [31:0]           read_data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic                  write_enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    act;
  logic                    illegal;

  // Burst type, the SEQ/NONSEQ distinction and the aliased address bits
  // carry no meaning for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

  // HREADY feeds back into the acceptance term, so while the first error
  // cycle holds HREADY low the bus cannot start a new transfer here.
  assign act     = HSEL & HTRANS[1] & HREADY;
  assign illegal = act & ((HSIZE != 3'b010) | (HADDR[1:0] != 2'b00));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= S_IDLE;
      addr_q <= '0;
    end else begin
      state <= next_state;
      // Captured for illegal transfers too; harmless since they never
      // reach the core.
      if (act) begin
        addr_q <= HADDR[ADDR_WIDTH+1:2];
      end
    end
  end

  always_comb begin
    next_state = S_IDLE;
    if (state == S_ERR1) begin
      next_state = S_ERR2;
    end else if (illegal) begin
      next_state = S_ERR1;
    end else if (act) begin
      next_state = HWRITE ? S_WRITE : S_READ;
    end
  end

  // Data-phase outputs depend on state only, so an asynchronous reset
  // clears them at once and drops any write that is in flight.
  always_comb begin
    HRDATA       = 32'h0;
    HREADY       = 1'b1;
    HRESP        = 1'b0;
    write_enable = 1'b0;
    unique case (state)
      S_READ:  HRDATA       = read_data;
      S_WRITE: write_enable = 1'b1;
      S_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      S_ERR2:  HRESP        = 1'b1;
      default: ;
    endcase
  end

  assign read_addr  = addr_q;
  assign write_addr = addr_q;
  assign write_data = HWDATA;

endmodule
